// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared constants for the PS/2 keyboard path: prefix bytes, the eight
// game key scan codes, the held-vector / press-vector bit positions and
// the key lookup used by the decode layer.
package ps2_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Player 0: arrow keys, sent with the E0 prefix
  localparam logic [7:0] SC_P0_LEFT  = 8'h6B;
  localparam logic [7:0] SC_P0_RIGHT = 8'h74;
  localparam logic [7:0] SC_P0_UP    = 8'h75;
  localparam logic [7:0] SC_P0_DOWN  = 8'h72;

  // Player 1: A / D / W / S, no prefix
  localparam logic [7:0] SC_P1_LEFT  = 8'h1C;
  localparam logic [7:0] SC_P1_RIGHT = 8'h23;
  localparam logic [7:0] SC_P1_UP    = 8'h1D;
  localparam logic [7:0] SC_P1_DOWN  = 8'h1B;

  localparam int KEY_P0_LEFT  = 0;
  localparam int KEY_P0_RIGHT = 1;
  localparam int KEY_P0_UP    = 2;
  localparam int KEY_P0_DOWN  = 3;
  localparam int KEY_P1_LEFT  = 4;
  localparam int KEY_P1_RIGHT = 5;
  localparam int KEY_P1_UP    = 6;
  localparam int KEY_P1_DOWN  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  // A code only matches when its prefix state agrees: arrows need ext=1,
  // letter keys need ext=0.
  function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = 3'd0;
    if (ext) begin
      case (code)
        SC_P0_LEFT:  r.idx = 3'(KEY_P0_LEFT);
        SC_P0_RIGHT: r.idx = 3'(KEY_P0_RIGHT);
        SC_P0_UP:    r.idx = 3'(KEY_P0_UP);
        SC_P0_DOWN:  r.idx = 3'(KEY_P0_DOWN);
        default:     r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_P1_LEFT:  r.idx = 3'(KEY_P1_LEFT);
        SC_P1_RIGHT: r.idx = 3'(KEY_P1_RIGHT);
        SC_P1_UP:    r.idx = 3'(KEY_P1_UP);
        SC_P1_DOWN:  r.idx = 3'(KEY_P1_DOWN);
        default:     r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
// PS/2 receiver: two-flop synchronizers, ps2_clk glitch filter, 11-bit
// frame FSM and inter-edge timeout.
//   clk, rst       system clock, synchronous active-low reset
//   ps2_clk/data   raw asynchronous PS/2 pins
//   scan_code      last good byte (held between frames)
//   scan_valid     one-cycle pulse, scan_code valid in that cycle
//   frame_err      one-cycle pulse on bad parity, bad stop or timeout
//
// state     | meaning
// ST_IDLE   | waiting for a falling edge with data=0 (start bit)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | sampling parity bit, odd parity over data+parity
// ST_STOP   | sampling stop bit, emit byte or error
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 20000,
  parameter int FILT_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int FILT_CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int TMO_CW  = $clog2(TIMEOUT_CYC + 1);

  logic               clk_s1, clk_s2, data_s1, data_s2;
  logic               filt_lvl;
  logic [FILT_CW-1:0] filt_cnt;
  logic               filt_flip, fall;

  frame_state_t       state;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               par_ok;
  logic [TMO_CW-1:0]  tmo_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1  <= 1'b0;
      clk_s2  <= 1'b0;
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // filt_cnt counts consecutive samples that disagree with the filtered
  // level; the level flips on the FILT_LEN-th such sample. The level resets
  // to 0 so a reset while ps2_clk is low cannot manufacture a falling edge.
  assign filt_flip = (clk_s2 != filt_lvl) && (filt_cnt == FILT_CW'(FILT_LEN - 1));
  assign fall      = filt_flip && filt_lvl;

  always_ff @(posedge clk) begin
    if (!rst) begin
      filt_lvl <= 1'b0;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_lvl) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      filt_lvl <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FILT_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_ok     <= 1'b0;
      tmo_cnt    <= '0;
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        // down-counter reloads on every edge; hitting 0 means TIMEOUT_CYC
        // edge-free cycles have elapsed
        tmo_cnt <= TMO_CW'(TIMEOUT_CYC - 1);
        case (state)
          ST_IDLE: begin
            if (!data_s2) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_ok <= ^{shreg, data_s2};
            state  <= ST_STOP;
          end
          ST_STOP: begin
            if (data_s2 && par_ok) begin
              scan_valid <= 1'b1;
              scan_code  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (tmo_cnt == '0) begin
          state     <= ST_IDLE;
          frame_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt - TMO_CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns PS/2 keyboard scan codes into one-cycle key-press pulses for the
// two snake players (arrows -> player 0, WASD -> player 1).
//   clk, rst              system clock, synchronous active-low reset
//   ps2_clk, ps2_data     raw PS/2 pins
//   *_key_press           player-0 press pulses
//   *_key_press_1         player-1 press pulses
//   scan_code/scan_valid  last accepted byte and its one-cycle strobe
//   frame_err             one-cycle pulse on any receive error
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 20000,
  parameter int FILT_LEN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       left_key_press,
  output logic       right_key_press,
  output logic       up_key_press,
  output logic       down_key_press,
  output logic       left_key_press_1,
  output logic       right_key_press_1,
  output logic       up_key_press_1,
  output logic       down_key_press_1,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  logic       ext, brk;
  logic [7:0] held;
  logic [7:0] press;
  key_hit_t   hit;

  ps2_rx_frame #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FILT_LEN    (FILT_LEN)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  assign hit = key_lookup(scan_code, ext);

  // held[] suppresses typematic repeats: only the first make after a
  // break (or after reset) produces a pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ext   <= 1'b0;
      brk   <= 1'b0;
      held  <= '0;
      press <= '0;
    end else begin
      press <= '0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (scan_valid) begin
        if (scan_code == SC_EXT) begin
          ext <= 1'b1;
        end else if (scan_code == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (hit.hit) begin
            if (brk) begin
              held[hit.idx] <= 1'b0;
            end else if (!held[hit.idx]) begin
              held[hit.idx]  <= 1'b1;
              press[hit.idx] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign left_key_press    = press[KEY_P0_LEFT];
  assign right_key_press   = press[KEY_P0_RIGHT];
  assign up_key_press      = press[KEY_P0_UP];
  assign down_key_press    = press[KEY_P0_DOWN];
  assign left_key_press_1  = press[KEY_P1_LEFT];
  assign right_key_press_1 = press[KEY_P1_RIGHT];
  assign up_key_press_1    = press[KEY_P1_UP];
  assign down_key_press_1  = press[KEY_P1_DOWN];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder. Timeout is shortened and the PS/2 clock
// runs fast so the whole run stays small; all timing expectations are
// derived from these parameters.
module tb_ps2_key_decoder;

  localparam int TMO = 300;
  localparam int FL  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic left_key_press, right_key_press, up_key_press, down_key_press;
  logic left_key_press_1, right_key_press_1, up_key_press_1, down_key_press_1;
  logic [7:0] scan_code;
  logic scan_valid, frame_err;

  ps2_key_decoder #(.TIMEOUT_CYC(TMO), .FILT_LEN(FL)) dut (
    .clk               (clk),
    .rst               (rst),
    .ps2_clk           (ps2_clk),
    .ps2_data          (ps2_data),
    .left_key_press    (left_key_press),
    .right_key_press   (right_key_press),
    .up_key_press      (up_key_press),
    .down_key_press    (down_key_press),
    .left_key_press_1  (left_key_press_1),
    .right_key_press_1 (right_key_press_1),
    .up_key_press_1    (up_key_press_1),
    .down_key_press_1  (down_key_press_1),
    .scan_code         (scan_code),
    .scan_valid        (scan_valid),
    .frame_err         (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int half = 20;

  // ---------------- observation (negedge, away from active edge) -------
  logic [7:0] pv;
  assign pv = {down_key_press_1, up_key_press_1, right_key_press_1, left_key_press_1,
               down_key_press, up_key_press, right_key_press, left_key_press};

  int  sv_q[$];
  int  pulse_q[$];
  int  err_n = 0;
  int  late_n = 0;
  int  multi_n = 0;
  int  both_n = 0;
  time err_t = 0;
  time last_fall_t = 0;
  logic sv_d = 1'b0;

  always @(negedge clk) begin
    if (scan_valid) sv_q.push_back(int'(scan_code));
    if (frame_err) begin
      err_n++;
      err_t = $time;
    end
    if (scan_valid && frame_err) both_n++;
    if (pv != 8'h00) begin
      if ($countones(pv) != 1) multi_n++;
      if (!sv_d) late_n++;
      for (int i = 0; i < 8; i++) if (pv[i]) pulse_q.push_back(i);
    end
    sv_d = scan_valid;
  end

  // ---------------- reference model ---------------------------------------
  // Key table: index -> (code, needs E0 prefix). 0-3 player 0 L/R/U/D,
  // 4-7 player 1 L/R/U/D.
  int key_code[8] = '{'h6B, 'h74, 'h75, 'h72, 'h1C, 'h23, 'h1D, 'h1B};
  bit key_ext[8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
  bit m_held[8];
  bit m_ext, m_brk;
  int exp_sv[$];
  int exp_pulse[$];
  int exp_err;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_held[i] = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_byte(input int b);
    int k;
    k = -1;
    exp_sv.push_back(b);
    if (b == 'hE0) m_ext = 1'b1;
    else if (b == 'hF0) m_brk = 1'b1;
    else begin
      for (int i = 0; i < 8; i++) if (key_code[i] == b && key_ext[i] == m_ext) k = i;
      if (k >= 0) begin
        if (m_brk) m_held[k] = 1'b0;
        else if (!m_held[k]) begin
          m_held[k] = 1'b1;
          exp_pulse.push_back(k);
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_err();
    exp_err++;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  function automatic bit q_same(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_obs();
    sv_q.delete();
    pulse_q.delete();
    err_n = 0;
    exp_sv.delete();
    exp_pulse.delete();
    exp_err = 0;
  endtask

  // ---------------- PS/2 drivers (inputs change on negedge) ---------------
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_t = $time;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input int b, input bit bad_par);
    logic [7:0] v;
    logic p;
    v = 8'(b);
    p = (~^v) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(v[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
  endtask

  task automatic send_good(input int b);
    send_frame(b, 1'b0);
    model_byte(b);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  // ---------------- tests ----------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (pv !== 8'h00) begin failures++; $display("FAIL reset_pulses got=%h exp=00", pv); end
    checks++; if (scan_code !== 8'h00) begin failures++; $display("FAIL reset_scan_code got=%h exp=00", scan_code); end
    checks++; if (scan_valid !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL reset_strobes got sv=%b err=%b exp 0 0", scan_valid, frame_err); end
    rst = 1'b1;
    model_reset();
    repeat (20) @(negedge clk);
  endtask

  task automatic test_single_make();
    clear_obs();
    send_good('h1D);
    settle();
    checks++; if (sv_q.size() != 1 || sv_q[0] != 'h1D) begin failures++; $display("FAIL single_scan got_n=%0d exp scan 1d", sv_q.size()); end
    checks++; if (pulse_q.size() != 1 || pulse_q[0] != 6) begin failures++; $display("FAIL single_pulse got_n=%0d exp one pulse on index 6", pulse_q.size()); end
    checks++; if (err_n != 0) begin failures++; $display("FAIL single_err got=%0d exp=0", err_n); end
  endtask

  task automatic test_typematic();
    int seq[9] = '{'hE0, 'h75, 'hE0, 'h75, 'hE0, 'hF0, 'h75, 'hE0, 'h75};
    clear_obs();
    foreach (seq[i]) send_good(seq[i]);
    settle();
    checks++; if (!q_same(pulse_q, exp_pulse)) begin failures++; $display("FAIL typematic_model got_n=%0d exp_n=%0d", pulse_q.size(), exp_pulse.size()); end
    checks++; if (pulse_q.size() != 2 || pulse_q[0] != 2 || pulse_q[1] != 2) begin failures++; $display("FAIL typematic_up got_n=%0d exp 2 up pulses", pulse_q.size()); end
    checks++; if (!q_same(sv_q, exp_sv)) begin failures++; $display("FAIL typematic_scan got_n=%0d exp_n=%0d", sv_q.size(), exp_sv.size()); end
  endtask

  task automatic test_parity_err();
    clear_obs();
    send_frame('h23, 1'b1);
    model_err();
    settle();
    checks++; if (err_n != 1) begin failures++; $display("FAIL parity_err got=%0d exp=1", err_n); end
    checks++; if (sv_q.size() != 0 || pulse_q.size() != 0) begin failures++; $display("FAIL parity_quiet got sv=%0d pulses=%0d exp 0 0", sv_q.size(), pulse_q.size()); end
    send_good('h23);
    settle();
    checks++; if (pulse_q.size() != 1 || pulse_q[0] != 5) begin failures++; $display("FAIL parity_recover got_n=%0d exp one pulse on index 5", pulse_q.size()); end
  endtask

  task automatic test_timeout();
    time t0;
    clear_obs();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    t0 = last_fall_t;
    ps2_data = 1'b1;
    repeat (TMO + 60) @(negedge clk);
    model_err();
    checks++; if (err_n != 1) begin failures++; $display("FAIL timeout_err got=%0d exp=1", err_n); end
    // edge seen FL+2 cycles after the pin falls, error TMO cycles later
    checks++; if (err_t - t0 != 10 * (TMO + FL + 2)) begin failures++; $display("FAIL timeout_time got=%0t exp=%0t", err_t - t0, 10 * (TMO + FL + 2)); end
    checks++; if (sv_q.size() != 0) begin failures++; $display("FAIL timeout_scan got=%0d exp=0", sv_q.size()); end
    send_good('h1C);
    settle();
    checks++; if (pulse_q.size() != 1 || pulse_q[0] != 4) begin failures++; $display("FAIL timeout_recover got_n=%0d exp one pulse on index 4", pulse_q.size()); end
  endtask

  task automatic test_wrong_ext();
    clear_obs();
    send_good('hE0);
    send_good('h1C);
    send_good('h6B);
    settle();
    checks++; if (pulse_q.size() != 0) begin failures++; $display("FAIL wrong_ext got_n=%0d exp=0", pulse_q.size()); end
    checks++; if (!q_same(sv_q, exp_sv)) begin failures++; $display("FAIL wrong_ext_scan got_n=%0d exp_n=%0d", sv_q.size(), exp_sv.size()); end
  endtask

  task automatic test_reset_mid_frame();
    clear_obs();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    checks++; if (pv !== 8'h00 || scan_code !== 8'h00) begin failures++; $display("FAIL midrst_outputs got pulses=%h code=%h exp 00 00", pv, scan_code); end
    repeat (TMO + 60) @(negedge clk);
    checks++; if (err_n != 0 || sv_q.size() != 0) begin failures++; $display("FAIL midrst_quiet got err=%0d sv=%0d exp 0 0", err_n, sv_q.size()); end
    send_good('hE0);
    send_good('h6B);
    settle();
    checks++; if (pulse_q.size() != 1 || pulse_q[0] != 0) begin failures++; $display("FAIL midrst_recover got_n=%0d exp one pulse on index 0", pulse_q.size()); end
  endtask

  task automatic test_back_to_back_random();
    int b;
    int r;
    clear_obs();
    for (int n = 0; n < 45; n++) begin
      half = $urandom_range(12, 25);
      r = $urandom_range(0, 9);
      if (r < 2) b = 'hE0;
      else if (r == 2) b = 'hF0;
      else if (r < 8) b = key_code[$urandom_range(0, 7)];
      else b = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) begin
        send_frame(b, 1'b1);
        model_err();
      end else begin
        send_good(b);
      end
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    half = 20;
    settle();
    checks++; if (!q_same(sv_q, exp_sv)) begin failures++; $display("FAIL random_scan got_n=%0d exp_n=%0d", sv_q.size(), exp_sv.size()); end
    checks++; if (!q_same(pulse_q, exp_pulse)) begin failures++; $display("FAIL random_pulses got_n=%0d exp_n=%0d", pulse_q.size(), exp_pulse.size()); end
    checks++; if (err_n != exp_err) begin failures++; $display("FAIL random_err got=%0d exp=%0d", err_n, exp_err); end
  endtask

  task automatic test_pulse_shape();
    checks++; if (late_n != 0) begin failures++; $display("FAIL pulse_latency got=%0d bad pulses exp=0", late_n); end
    checks++; if (multi_n != 0) begin failures++; $display("FAIL pulse_multi got=%0d exp=0", multi_n); end
    checks++; if (both_n != 0) begin failures++; $display("FAIL valid_and_err got=%0d exp=0", both_n); end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_typematic();
    test_parity_err();
    test_timeout();
    test_wrong_ext();
    test_reset_mid_frame();
    test_back_to_back_random();
    test_pulse_shape();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
